ring_decoder: RTL

- Receive-side companion to the 4-stage ring counter: samples the one-hot ring state and decodes it to a binary stage index.
- Locks onto the rotation sequence, counts completed revolutions, and flags illegal (non-one-hot) or out-of-sequence states.
- Sits downstream of the ring counter outputs; presents index, lock status and error flags to control/monitor logic.

---
 rtl/ring_decoder.sv | 116 +++++++++++
 1 files changed

// File: rtl/ring_decoder.sv
// Receive-side decoder for a one-hot ring counter. It turns the sampled ring state
// into a binary stage index, locks onto the rotation, counts revolutions and flags bad states.
module ring_decoder #(
    parameter int N        = 4,
    parameter int W        = $clog2(N),
    parameter int REV_W    = 8,
    parameter int LOCK_CNT = 2
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [N-1:0]     RING_IN,
    input  logic             IN_VALID,
    input  logic             ERR_CLR,
    output logic [W-1:0]     IDX,
    output logic             IDX_VALID,
    output logic             LOCKED,
    output logic             ILLEGAL,
    output logic             SKIP,
    output logic             ERR,
    output logic [REV_W-1:0] REV_CNT
);

    typedef enum logic {
        HUNT,
        TRACK
    } state_t;

    state_t       state;
    logic [N-1:0] prev;
    logic [3:0]   streak;

    logic         one_hot;
    logic [W-1:0] sample_idx;
    logic [N-1:0] expected;
    logic         match;
    logic         wrap;
    logic [3:0]   streak_inc;
    logic         new_err;

    // An all-zero prev means "no reference yet", so nothing can match it.
    always_comb begin
        one_hot    = (RING_IN != '0) && ((RING_IN & (RING_IN - N'(1))) == '0);
        sample_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (RING_IN[i]) sample_idx = W'(i);
        end
        expected   = {prev[N-2:0], prev[N-1]};
        match      = (prev != '0) && (RING_IN == expected);
        wrap       = prev[N-1] && RING_IN[0];
        streak_inc = streak + 4'd1;
        new_err    = IN_VALID && (!one_hot || (state == TRACK && !match));
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state     <= HUNT;
            prev      <= '0;
            streak    <= '0;
            IDX       <= '0;
            IDX_VALID <= 1'b0;
            LOCKED    <= 1'b0;
            ILLEGAL   <= 1'b0;
            SKIP      <= 1'b0;
            ERR       <= 1'b0;
            REV_CNT   <= '0;
        end else begin
            IDX_VALID <= 1'b0;
            ILLEGAL   <= 1'b0;
            SKIP      <= 1'b0;

            if (IN_VALID && !one_hot) begin
                ILLEGAL <= 1'b1;
                prev    <= '0;
                streak  <= '0;
                state   <= HUNT;
                LOCKED  <= 1'b0;
            end else if (IN_VALID) begin
                IDX       <= sample_idx;
                IDX_VALID <= 1'b1;
                prev      <= RING_IN;
                case (state)
                    HUNT: begin
                        if (match) begin
                            if (streak_inc >= 4'(LOCK_CNT)) begin
                                state  <= TRACK;
                                LOCKED <= 1'b1;
                                streak <= '0;
                            end else begin
                                streak <= streak_inc;
                            end
                        end else begin
                            streak <= '0;
                        end
                    end
                    TRACK: begin
                        // A repeated (stuck) stage is treated the same as a jump.
                        if (match) begin
                            if (wrap) REV_CNT <= REV_CNT + REV_W'(1);
                        end else begin
                            SKIP   <= 1'b1;
                            state  <= HUNT;
                            streak <= '0;
                            LOCKED <= 1'b0;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end

            // A fresh error wins over a simultaneous clear request.
            if (new_err) ERR <= 1'b1;
            else if (ERR_CLR) ERR <= 1'b0;
        end
    end

endmodule
